// File: rtl/alu_seq.sv
// alu_seq: handshaked signed ALU with single-cycle logic/arithmetic ops,
// bit-serial shifts (one position per cycle) and a shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t st, st_nxt;

  // Working datapath registers: operands, multiplier partial product, step count
  logic [3:0]              op_q;
  logic signed [WIDTH-1:0] wa;
  logic signed [WIDTH-1:0] wb;
  logic [2*WIDTH-1:0]      mc;
  logic [2*WIDTH-1:0]      prod;
  logic [CW-1:0]           cnt;
  logic                    cbit;

  logic                    accept;
  logic                    done_c;
  logic [WIDTH:0]          sum_c;
  logic [WIDTH-1:0]        res_c;
  logic                    c_c;
  logic                    v_c;

  // Signed overflow of x + y giving r: same-sign operands, result sign differs
  function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign accept = in_valid && in_ready;
  assign done_c = (st == EXEC) && (cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // Next-state logic: an op finishes when its step counter reaches zero
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid) st_nxt = EXEC;
      EXEC:    if (cnt == '0) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
  end

  // Operand capture on accept, then one shift / multiplier bit per EXEC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= cmd;
      wa   <= a;
      wb   <= b;
      mc   <= {{WIDTH{1'b0}}, a};
      prod <= '0;
      cbit <= 1'b0;
      case (cmd)
        OP_SLL, OP_SRL, OP_SRA: cnt <= CW'(b[SHW-1:0]);
        OP_MUL:                 cnt <= CW'(WIDTH);
        default:                cnt <= '0;
      endcase
    end else if (st == EXEC && cnt != '0) begin
      cnt <= cnt - 1'b1;
      case (op_q)
        OP_SLL: begin
          cbit <= wa[WIDTH-1];
          wa   <= wa << 1;
        end
        OP_SRL: begin
          cbit <= wa[0];
          wa   <= wa >> 1;
        end
        OP_SRA: begin
          cbit <= wa[0];
          wa   <= wa >>> 1;
        end
        OP_MUL: begin
          prod <= prod + (wb[0] ? mc : '0);
          mc   <= mc << 1;
          wb   <= wb >> 1;
        end
        default: ;
      endcase
    end
  end

  // Final result and C/V for the completing op
  always_comb begin
    sum_c = '0;
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum_c = {1'b0, wa} + {1'b0, wb};
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = add_ovf(wa, wb, res_c);
      end
      OP_SUB: begin
        sum_c = {1'b0, wa} + {1'b0, ~wb} + (WIDTH+1)'(1);
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = add_ovf(wa, ~wb, res_c);
      end
      OP_NOT: res_c = ~wa;
      OP_AND: res_c = wa & wb;
      OP_OR:  res_c = wa | wb;
      OP_XOR: res_c = wa ^ wb;
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, (wa < wb)};
      OP_EQ:  res_c = {{(WIDTH-1){1'b0}}, (wa == wb)};
      OP_SLL, OP_SRL, OP_SRA: begin
        res_c = wa;
        c_c   = cbit;
      end
      OP_MUL: begin
        res_c = prod[WIDTH-1:0];
        c_c   = |prod[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Result/flag register, loaded on completion and held through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (done_c) begin
      out    <= res_c;
      flag_z <= (res_c == '0);
      flag_n <= res_c[WIDTH-1];
      flag_c <= c_c;
      flag_v <= v_c;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, backpressure and reset sequences, and
// randomized ops against an arithmetic reference model, at WIDTH 4 and 16.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv4, ir4, ov4, ordy4, z4, n4, c4, v4;
  logic [3:0]  a4, b4, cmd4, o4;
  logic        iv16, ir16, ov16, ordy16, z16, n16, c16, v16;
  logic [15:0] a16, b16, o16;
  logic [3:0]  cmd16;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cmd(cmd4), .out_valid(ov4), .out_ready(ordy4), .out(o4),
    .flag_z(z4), .flag_n(n4), .flag_c(c4), .flag_v(v4)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cmd(cmd16), .out_valid(ov16), .out_ready(ordy16), .out(o16),
    .flag_z(z16), .flag_n(n16), .flag_c(c16), .flag_v(v16)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic get_ov(input int w);
    return (w == 4) ? ov4 : ov16;
  endfunction
  function automatic logic get_ir(input int w);
    return (w == 4) ? ir4 : ir16;
  endfunction
  function automatic longint get_out(input int w);
    return (w == 4) ? longint'(o4) : longint'(o16);
  endfunction
  function automatic logic [3:0] get_fl(input int w);
    return (w == 4) ? {z4, n4, c4, v4} : {z16, n16, c16, v16};
  endfunction

  task automatic drive(input int w, input logic v, input longint av, input longint bv,
                       input logic [3:0] c);
    logic [15:0] a_t, b_t;
    a_t = av[15:0];
    b_t = bv[15:0];
    if (w == 4) begin iv4 = v; a4 = a_t[3:0]; b4 = b_t[3:0]; cmd4 = c; end
    else begin iv16 = v; a16 = a_t; b16 = b_t; cmd16 = c; end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 4) ordy4 = r;
    else ordy16 = r;
  endtask

  // Reference: result, {Z,N,C,V} and latency from the opcode definitions
  task automatic model(input int w, input logic [3:0] c, input longint ua, input longint ub,
                       output longint res, output logic [3:0] fl, output int lat);
    longint mask, sa, sb, full, lo, hi, p;
    int sh;
    logic cf, vf;
    mask = (longint'(1) << w) - 1;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    sa = (ua > hi) ? ua - (longint'(1) << w) : ua;
    sb = (ub > hi) ? ub - (longint'(1) << w) : ub;
    sh = int'(ub & longint'(w - 1));
    cf = 1'b0; vf = 1'b0; lat = 1; res = 0;
    case (c)
      4'd0: begin full = ua + ub; res = full & mask; cf = full[w];
                  vf = (sa + sb < lo) || (sa + sb > hi); end
      4'd1: begin full = ua + ((~ub) & mask) + 1; res = full & mask; cf = full[w];
                  vf = (sa - sb < lo) || (sa - sb > hi); end
      4'd2: res = (~ua) & mask;
      4'd3: res = ua & ub;
      4'd4: res = ua | ub;
      4'd5: res = ua ^ ub;
      4'd6: res = (sa < sb) ? 1 : 0;
      4'd7: res = (ua == ub) ? 1 : 0;
      4'd8: begin res = (ua << sh) & mask; cf = (sh == 0) ? 1'b0 : ua[w - sh];
                  lat = 1 + sh; end
      4'd9: begin res = ua >> sh; cf = (sh == 0) ? 1'b0 : ua[sh - 1]; lat = 1 + sh; end
      4'd10: begin res = (sa >>> sh) & mask; cf = (sh == 0) ? 1'b0 : ua[sh - 1];
                   lat = 1 + sh; end
      4'd11: begin p = ua * ub; res = p & mask; cf = ((p >> w) != 0); lat = w + 1; end
      default: res = 0;
    endcase
    fl = {(res == 0), res[w - 1], cf, vf};
  endtask

  // One full transaction: accept, measure latency, check result, optional stall, release
  task automatic run_op(input int w, input logic [3:0] c, input longint av, input longint bv,
                        input longint eo, input logic [3:0] ef, input int elat,
                        input int stall, input string tag);
    int guard, lat;
    logic got;
    guard = 0;
    while (!get_ir(w) && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!get_ir(w)) begin check({tag, "_in_ready"}, 0, 1); return; end
    drive(w, 1'b1, av, bv, c);
    @(posedge clk); #1;
    drive(w, 1'b0, 0, 0, 4'd0);
    lat = 0; got = 1'b0;
    while (!got && lat < 64) begin @(posedge clk); #1; lat++; got = get_ov(w); end
    check({tag, "_latency"}, lat, elat);
    if (!got) return;
    check({tag, "_out"}, get_out(w), eo);
    check({tag, "_flags"}, get_fl(w), ef);
    repeat (stall) begin @(posedge clk); #1; end
    if (stall > 0) check({tag, "_held"}, get_out(w), eo);
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
    check({tag, "_release"}, {get_ov(w), get_ir(w)}, 2'b01);
  endtask

  typedef struct {
    int         w;
    logic [3:0] cmd;
    longint     a;
    longint     b;
    longint     eo;
    logic [3:0] ef;
    int         lat;
  } vec_t;

  vec_t tbl[19];

  initial begin
    longint ra, rb, eo, mask;
    logic [3:0] ef, rc;
    int lat, w;

    tbl[0]  = '{4, 4'd0, 7, 1, 8, 4'b0101, 1};
    tbl[1]  = '{4, 4'd1, 3, 3, 0, 4'b1010, 1};
    tbl[2]  = '{4, 4'd6, 'hE, 1, 1, 4'b0000, 1};
    tbl[3]  = '{4, 4'd7, 5, 5, 1, 4'b0000, 1};
    tbl[4]  = '{4, 4'd10, 'h8, 3, 'hF, 4'b0100, 4};
    tbl[5]  = '{4, 4'd8, 'h6, 0, 'h6, 4'b0000, 1};
    tbl[6]  = '{4, 4'd11, 5, 3, 'hF, 4'b0100, 5};
    tbl[7]  = '{4, 4'd11, 6, 6, 4, 4'b0010, 5};
    tbl[8]  = '{4, 4'd13, 5, 5, 0, 4'b1000, 1};
    tbl[9]  = '{4, 4'd1, 0, 1, 'hF, 4'b0100, 1};
    tbl[10] = '{4, 4'd0, 8, 8, 0, 4'b1011, 1};
    tbl[11] = '{4, 4'd9, 'hB, 2, 2, 4'b0010, 3};
    tbl[12] = '{4, 4'd8, 7, 1, 'hE, 4'b0100, 2};
    tbl[13] = '{16, 4'd0, 'h7FFF, 1, 'h8000, 4'b0101, 1};
    tbl[14] = '{16, 4'd1, 3, 3, 0, 4'b1010, 1};
    tbl[15] = '{16, 4'd10, 'h8000, 15, 'hFFFF, 4'b0100, 16};
    tbl[16] = '{16, 4'd11, 'h100, 'h100, 0, 4'b1010, 17};
    tbl[17] = '{16, 4'd11, 5, 3, 15, 4'b0000, 17};
    tbl[18] = '{16, 4'd8, 1, 'h13, 8, 4'b0000, 4};

    rst = 1'b1;
    drive(4, 1'b0, 0, 0, 4'd0); drive(16, 1'b0, 0, 0, 4'd0);
    ordy4 = 1'b0; ordy16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_w4", {ov4, o4, z4, n4, c4, v4}, 0);
    check("reset_w16", {ov16, o16, z16, n16, c16, v16}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_ready", {ir4, ir16}, 2'b11);

    // Directed vector table
    for (int i = 0; i < 19; i++)
      run_op(tbl[i].w, tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].eo, tbl[i].ef, tbl[i].lat,
             (i % 3), $sformatf("vec%0d", i));

    // Backpressure: result held, new requests ignored, next op accepted after release
    drive(4, 1'b1, 2, 3, 4'd0);
    @(posedge clk); #1;
    drive(4, 1'b1, 7, 7, 4'd0);
    @(posedge clk); #1;
    check("bp_valid", ov4, 1);
    for (int k = 0; k < 10; k++) begin
      drive(4, 1'b1, k, 1, 4'd0);
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), {ov4, ir4, o4}, {1'b1, 1'b0, 4'd5});
    end
    drive(4, 1'b1, 1, 1, 4'd0);
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
    check("bp_release", {ov4, ir4}, 2'b01);
    @(posedge clk); #1;
    drive(4, 1'b0, 0, 0, 4'd0);
    check("bp_accepted", ir4, 0);
    @(posedge clk); #1;
    check("bp_next_result", {ov4, o4}, {1'b1, 4'd2});
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;

    // Reset in the middle of a multiply
    for (int j = 0; j < 2; j++) begin
      w = (j == 0) ? 4 : 16;
      mask = (longint'(1) << w) - 1;
      drive(w, 1'b1, mask, mask, 4'd11);
      @(posedge clk); #1;
      drive(w, 1'b0, 0, 0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check($sformatf("rst_mid_mul_w%0d", w), {get_ov(w), get_out(w), get_fl(w)}, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check($sformatf("rst_mid_mul_ready_w%0d", w), {get_ir(w), get_ov(w)}, 2'b10);
    end

    // Randomized ops against the reference model
    for (int j = 0; j < 2; j++) begin
      w = (j == 0) ? 4 : 16;
      mask = (longint'(1) << w) - 1;
      for (int i = 0; i < 120; i++) begin
        ra = longint'($urandom) & mask;
        rb = longint'($urandom) & mask;
        rc = 4'($urandom_range(0, 15));
        model(w, rc, ra, rb, eo, ef, lat);
        run_op(w, rc, ra, rb, eo, ef, lat, int'($urandom_range(0, 2)),
               $sformatf("rnd_w%0d_op%0d_a%0h_b%0h", w, rc, ra, rb));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
